prince_word_io: RTL and testbench

- Sequential 32-bit word-stream front/back end for the combinational PRINCE datapath (prince_top).
- Assembles a 128-bit key and a 64-bit text block from 32-bit input words and drives the core's plaintext/key/mode inputs.
- Waits a fixed settle time, captures the core result and returns it as two 32-bit output words.
- Valid/ready handshakes on both sides; one block in flight at a time.

---
 rtl/prince_word_io_if.sv | 30 +++
 rtl/prince_word_io.sv | 170 +++++++++++++++++
 tb/tb_prince_word_io.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prince_word_io_if.sv
// rtl/prince_word_io_if.sv - word stream bundle between a host and prince_word_io
//
// Two valid/ready word channels sharing one bundle.
// Input channel (host -> block):
//   in_valid, in_ready, in_sel (0 key / 1 data), in_mode (0 enc / 1 dec), in_data[31:0]
// Output channel (block -> host):
//   out_valid, out_ready, out_data[31:0]
// Modports:
//   slave  - the word-io block side
//   master - the host side
interface prince_word_io_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic        in_mode;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_sel, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_sel, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/prince_word_io.sv
// rtl/prince_word_io.sv - 32-bit word-stream front/back end for a combinational PRINCE core
//
// Collects a 128-bit key and a 64-bit text block as 32-bit words (most-significant
// word first), presents them to the core, waits for the core to settle, then returns
// the 64-bit result as two 32-bit words. One block in flight at a time.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   bus             prince_word_io_if.slave: input and output word channels
//   busy            high while a block is settling or being returned
//   core_plaintext  text block to the core
//   core_key        key to the core
//   core_mode       0 encrypt / 1 decrypt to the core
//   core_ciphertext result from the core
//   blk_count       (only with PRINCE_WORD_IO_CNT_EN) completed blocks, wrapping 16-bit
//
// Parameters:
//   SETTLE_CYCLES   core settle cycles, 1..15
//   WORD_SIZE       word width, fixed at 32
//
// Optional feature macro: PRINCE_WORD_IO_CNT_EN
module prince_word_io #(
  parameter int SETTLE_CYCLES = 1,
  parameter int WORD_SIZE     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prince_word_io_if.slave       bus,
  output logic                  busy,
  output logic [63:0]           core_plaintext,
  output logic [127:0]          core_key,
  output logic                  core_mode,
  input  logic [63:0]           core_ciphertext
`ifdef PRINCE_WORD_IO_CNT_EN
  ,
  output logic [15:0]           blk_count
`endif
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    OUT_HI = 2'd2,
    OUT_LO = 2'd3
  } state_t;

  // WAIT lasts SETTLE_CYCLES+1 cycles: in the first one the core inputs have just
  // been updated, after that the core gets SETTLE_CYCLES full cycles to settle
  // before the capture edge.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t        state;
  state_t        state_nxt;
  logic [127:0]  key_reg;
  logic [63:0]   text_reg;
  logic [63:0]   res_reg;
  logic          mode_reg;
  logic          data_cnt;
  logic [3:0]    settle_cnt;

  logic          in_ready_i;
  logic          out_valid_i;
  logic [31:0]   out_data_i;
  logic          in_fire;
  logic          out_fire;

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_data  = out_data_i;

  assign in_fire  = in_ready_i & bus.in_valid;
  assign out_fire = out_valid_i & bus.out_ready;

  assign core_plaintext = text_reg;
  assign core_key       = key_reg;
  assign core_mode      = mode_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_i  = 1'b0;
    out_valid_i = 1'b0;
    out_data_i  = '0;
    busy        = 1'b1;
    case (state)
      LOAD: begin
        in_ready_i = 1'b1;
        busy       = 1'b0;
        // Second data word closes the block.
        if (bus.in_valid && bus.in_sel && data_cnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = OUT_HI;
        end
      end
      OUT_HI: begin
        out_valid_i = 1'b1;
        out_data_i  = res_reg[63:32];
        if (bus.out_ready) begin
          state_nxt = OUT_LO;
        end
      end
      OUT_LO: begin
        out_valid_i = 1'b1;
        out_data_i  = res_reg[31:0];
        if (bus.out_ready) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      text_reg   <= '0;
      mode_reg   <= 1'b0;
      res_reg    <= '0;
      data_cnt   <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (in_fire) begin
        if (!bus.in_sel) begin
          // Key words shift in from the right; no count, the key persists.
          key_reg <= {key_reg[127-WORD_SIZE:0], bus.in_data};
        end else if (!data_cnt) begin
          text_reg[63:32] <= bus.in_data;
          data_cnt        <= 1'b1;
        end else begin
          text_reg[31:0] <= bus.in_data;
          mode_reg       <= bus.in_mode;
          data_cnt       <= 1'b0;
          settle_cnt     <= '0;
        end
      end
      if (state == WAIT) begin
        settle_cnt <= settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) begin
          res_reg <= core_ciphertext;
        end
      end
    end
  end

`ifdef PRINCE_WORD_IO_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count <= '0;
    end else if (out_fire && (state == OUT_LO)) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prince_word_io.sv
// tb/tb_prince_word_io.sv - self-checking bench for prince_word_io with a stand-in core
module tb_prince_word_io;

  localparam int S = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         busy;
  logic [63:0]  core_plaintext;
  logic [63:0]  core_ciphertext;
  logic [127:0] core_key;
  logic         core_mode;
`ifdef PRINCE_WORD_IO_CNT_EN
  logic [15:0]  blk_count;
`endif

  prince_word_io_if bus ();

  prince_word_io #(.SETTLE_CYCLES(S), .WORD_SIZE(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .busy            (busy),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_mode       (core_mode),
    .core_ciphertext (core_ciphertext)
`ifdef PRINCE_WORD_IO_CNT_EN
    ,
    .blk_count       (blk_count)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in core: known PRINCE answers for the directed vectors, a keyed mix otherwise.
  function automatic logic [63:0] core_fn(input logic [63:0] t, input logic [127:0] k, input logic m);
    if (k == '0 && !m && t == 64'h0) return 64'h818665aa0d02dfda;
    if (k == '0 && !m && t == 64'hffffffffffffffff) return 64'h604ae6ca03c20ada;
    if (k == '0 && m && t == 64'h818665aa0d02dfda) return 64'h0;
    return t ^ k[127:64] ^ {k[31:0], k[63:32]} ^ {64{m}} ^ 64'h0123456789abcdef;
  endfunction

  assign core_ciphertext = core_fn(core_plaintext, core_key, core_mode);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: transaction level, updated from what the bench sees handshake.
  logic [127:0] m_key  = '0;
  logic [63:0]  m_text = '0;
  logic         m_mode = 1'b0;
  bit           m_half = 1'b0;
  int           m_wait = 0;
  logic [15:0]  m_blk  = '0;
  logic [31:0]  m_outq[$];
  logic [31:0]  rxq[$];

  initial begin
    bit          exp_ready;
    bit          exp_valid;
    logic [31:0] exp_data;
    logic [63:0] r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_key = '0; m_text = '0; m_mode = 1'b0; m_half = 1'b0;
        m_wait = 0; m_blk = '0; m_outq.delete();
      end
      exp_ready = (m_wait == 0) && (m_outq.size() == 0);
      exp_valid = m_outq.size() > 0;
      exp_data  = exp_valid ? m_outq[0] : 32'h0;
      chk("in_ready", bus.in_ready, exp_ready);
      chk("out_valid", bus.out_valid, exp_valid);
      chk("out_data", bus.out_data, exp_data);
      chk("busy", busy, !exp_ready);
      chk("core_key", core_key, m_key);
      chk("core_plaintext", core_plaintext, m_text);
      chk("core_mode", core_mode, m_mode);
`ifdef PRINCE_WORD_IO_CNT_EN
      chk("blk_count", blk_count, m_blk);
`endif
      if (rst_n) begin
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin
            r = core_fn(m_text, m_key, m_mode);
            m_outq.push_back(r[63:32]);
            m_outq.push_back(r[31:0]);
          end
        end
        if (exp_valid && bus.out_ready) begin
          rxq.push_back(m_outq.pop_front());
          if (m_outq.size() == 0) m_blk++;
        end
        if (exp_ready && bus.in_valid) begin
          if (!bus.in_sel) begin
            m_key = {m_key[95:0], bus.in_data};
          end else if (!m_half) begin
            m_text[63:32] = bus.in_data;
            m_half = 1'b1;
          end else begin
            m_text[31:0] = bus.in_data;
            m_mode = bus.in_mode;
            m_half = 1'b0;
            m_wait = S + 1;
          end
        end
      end
    end
  end

  // Sole driver of out_ready: fixed level or random per cycle.
  bit ready_rand  = 1'b0;
  bit ready_fixed = 1'b0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input bit sel, input bit mode, input logic [31:0] d);
    int t = 0;
    bus.in_valid = 1'b1; bus.in_sel = sel; bus.in_mode = mode; bus.in_data = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready got 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sel = 1'($urandom_range(0, 1));
    bus.in_mode = 1'($urandom_range(0, 1));
    bus.in_data = $urandom;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic recv2(output logic [31:0] hi, output logic [31:0] lo);
    int t = 0;
    while (rxq.size() < 2 && t <= 300) begin @(posedge clk); #1; t++; end
    if (rxq.size() < 2) begin
      checks++; errors++;
      $display("FAIL recv_timeout: words got %0d expected 2", rxq.size());
      hi = '0; lo = '0;
    end else begin
      hi = rxq.pop_front();
      lo = rxq.pop_front();
    end
  endtask

  task automatic zero_block();
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 32'h0);
    send(1'b1, 1'b0, 32'h0);
    send(1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: time got %0t expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] hi, lo;
    int lat, t;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_mode = 1'b0; bus.in_data = 32'hdeadbeef;

    // Reset with in_valid asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_plaintext", core_plaintext, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    gap(1);

    // Encrypt zero key / zero text, with latency measurement.
    ready_fixed = 1'b1;
    zero_block();
    lat = 0;
    while (lat <= 40) begin
      @(posedge clk); lat++; #1;
      if (bus.out_valid) break;
    end
    chk("latency", lat, S + 1);
    recv2(hi, lo);
    chk("enc0_hi", hi, 32'h818665aa);
    chk("enc0_lo", lo, 32'h0d02dfda);

    // Encrypt all-ones text, key unchanged.
    send(1'b1, 1'b0, 32'hffffffff);
    send(1'b1, 1'b0, 32'hffffffff);
    recv2(hi, lo);
    chk("enc1_hi", hi, 32'h604ae6ca);
    chk("enc1_lo", lo, 32'h03c20ada);

    // Decrypt with the persisting key.
    send(1'b1, 1'b0, 32'h818665aa);
    send(1'b1, 1'b1, 32'h0d02dfda);
    recv2(hi, lo);
    chk("dec_hi", hi, 32'h0);
    chk("dec_lo", lo, 32'h0);

    // Back-pressure in OUT_HI, input word offered during OUT_LO.
    ready_fixed = 1'b0;
    gap(1);
    send(1'b1, 1'b0, 32'h0);
    send(1'b1, 1'b0, 32'h0);
    t = 0;
    while (!bus.out_valid && t < 50) begin @(negedge clk); t++; end
    chk("bp_valid", bus.out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", bus.out_data, 32'h818665aa);
      chk("bp_hold_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    ready_fixed = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_mode = 1'b0; bus.in_data = 32'h0;
    @(negedge clk);
    chk("bp_lo_data", bus.out_data, 32'h0d02dfda);
    chk("bp_lo_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("bp_next_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    send(1'b1, 1'b0, 32'h0);
    recv2(hi, lo);
    chk("bp_hi", hi, 32'h818665aa);
    chk("bp_lo", lo, 32'h0d02dfda);
    recv2(hi, lo);
    chk("bp2_hi", hi, 32'h818665aa);
    chk("bp2_lo", lo, 32'h0d02dfda);

    // Reset in the middle of a block.
    send(1'b1, 1'b0, 32'h12345678);
    send(1'b0, 1'b0, 32'haaaaaaaa);
    send(1'b0, 1'b0, 32'hbbbbbbbb);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef PRINCE_WORD_IO_CNT_EN
    chk("cnt_after_rst", blk_count, 16'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    rxq.delete();
    zero_block();
    recv2(hi, lo);
    chk("rst_blk_hi", hi, 32'h818665aa);
    chk("rst_blk_lo", lo, 32'h0d02dfda);
`ifdef PRINCE_WORD_IO_CNT_EN
    chk("cnt_one", blk_count, 16'd1);
`endif

    // Randomized traffic with random output back-pressure.
    rxq.delete();
    ready_rand = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int nk;
      nk = $urandom_range(0, 4);
      for (int k = 0; k < nk; k++) begin
        gap($urandom_range(0, 2));
        send(1'b0, 1'($urandom_range(0, 1)), $urandom);
      end
      gap($urandom_range(0, 2));
      send(1'b1, 1'($urandom_range(0, 1)), $urandom);
      nk = $urandom_range(0, 2);
      for (int k = 0; k < nk; k++) begin
        gap($urandom_range(0, 1));
        send(1'b0, 1'($urandom_range(0, 1)), $urandom);
      end
      gap($urandom_range(0, 2));
      send(1'b1, 1'($urandom_range(0, 1)), $urandom);
    end
    t = 0;
    while ((m_wait != 0 || m_outq.size() != 0) && t < 500) begin @(posedge clk); #1; t++; end
    ready_rand = 1'b0;
    ready_fixed = 1'b1;
    gap(2);
    chk("rand_words", rxq.size(), 80);
    chk("rand_idle", bus.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
